// File: rtl/arb_pkg.sv
// Shared types and constants for the 8-way round-robin MSB arbiter.
// Imported by the arbiter top and its encoder.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int ARB_N        = 8;
    localparam int ARB_IDX_W    = 3;
    localparam int ARB_MAX_HOLD = 16;

    // One-hot decode of an owner index.
    function automatic logic [ARB_N-1:0] idx2oh(
        input logic [ARB_IDX_W-1:0] i
    );
        logic [ARB_N-1:0] oh;
        oh    = '0;
        oh[i] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/msb_enc.sv
// Highest-set-bit encoder for an 8-bit vector.
// idx is 0 when the vector is empty; any flags a non-empty vector.
module msb_enc
    import arb_pkg::*;
(
    input  logic [7:0] vec,
    output logic [2:0] idx,
    output logic       any
);

    assign any = |vec;

    // Highest set bit wins.
    always_comb begin
        idx = 3'd0;
        priority case (1'b1)
            vec[7]:  idx = 3'd7;
            vec[6]:  idx = 3'd6;
            vec[5]:  idx = 3'd5;
            vec[4]:  idx = 3'd4;
            vec[3]:  idx = 3'd3;
            vec[2]:  idx = 3'd2;
            vec[1]:  idx = 3'd1;
            default: idx = 3'd0;
        endcase
    end

endmodule

// File: rtl/rr_msb_arbiter.sv
// Round-robin arbiter, 8 requesters, descending MSB rotation.
// Each grant is capped at MAX_HOLD cycles, then revoked with a timeout pulse.
module rr_msb_arbiter
    import arb_pkg::*;
#(
    parameter int N        = ARB_N,
    parameter int IDX_W    = ARB_IDX_W,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             timeout
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t           state_q;
    logic [N-1:0]     gnt_q;
    logic             gnt_valid_q;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] last_q;
    logic [7:0]       hold_q;
    logic             timeout_q;

    logic [N-1:0]     mask_w;
    logic [N-1:0]     masked_w;
    logic [IDX_W-1:0] m_idx;
    logic [IDX_W-1:0] r_idx;
    logic             m_any;
    logic             r_any;
    logic [IDX_W-1:0] win_w;
    logic             own_req_w;

    // Only indices strictly below the last winner are eligible first.
    assign mask_w   = (N'(1) << last_q) - N'(1);
    assign masked_w = req & mask_w;

    msb_enc u_enc_masked (
        .vec (masked_w),
        .idx (m_idx),
        .any (m_any)
    );

    msb_enc u_enc_req (
        .vec (req),
        .idx (r_idx),
        .any (r_any)
    );

    assign win_w     = m_any ? m_idx : r_idx;
    assign own_req_w = req[idx_q];

    // Grant FSM with registered outputs; timeout only lives for one cycle.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            idx_q       <= '0;
            last_q      <= '0;
            hold_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (r_any) begin
                        gnt_q       <= idx2oh(win_w);
                        gnt_valid_q <= 1'b1;
                        idx_q       <= win_w;
                        last_q      <= win_w;
                        hold_q      <= '0;
                        state_q     <= GRANT;
                    end else begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!own_req_w) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else if (hold_q == HOLD_LAST) begin
                        gnt_q       <= '0;
                        gnt_valid_q <= 1'b0;
                        timeout_q   <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        hold_q <= hold_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_idx   = idx_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_msb_arbiter.sv
// Directed table-driven bench for rr_msb_arbiter with MAX_HOLD=4.
// Each row drives req/reset for one cycle and checks outputs after the edge.
module tb_rr_msb_arbiter;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] gnt;
        logic       vld;
        logic [2:0] idx;
        logic       to;
    } vec_t;

    logic       clock;
    logic       resetn;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;
    logic       timeout;

    int checks;
    int failures;
    vec_t tbl[$];

    rr_msb_arbiter #(
        .N        (8),
        .IDX_W    (3),
        .MAX_HOLD (4)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req       (req),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .timeout   (timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic add(input logic r, input logic [7:0] rq,
                       input logic [7:0] g, input logic v,
                       input logic [2:0] i, input logic t);
        vec_t e;
        e.rst = r;
        e.req = rq;
        e.gnt = g;
        e.vld = v;
        e.idx = i;
        e.to  = t;
        tbl.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] g,
                         input logic v, input logic [2:0] i,
                         input logic t);
        checks++;
        if (gnt !== g || gnt_valid !== v || gnt_idx !== i || timeout !== t) begin
            failures++;
            $display("FAIL %s: got gnt=%b vld=%b idx=%0d to=%b, want gnt=%b vld=%b idx=%0d to=%b",
                     name, gnt, gnt_valid, gnt_idx, timeout, g, v, i, t);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetn   = 1'b0;
        req      = 8'h00;

        // Reset state, then two requesters: 5 first, then 2 after release.
        add(1, 8'h00, 8'h00, 0, 3'd0, 0);
        add(1, 8'h24, 8'h00, 0, 3'd0, 0);
        add(0, 8'h24, 8'h20, 1, 3'd5, 0);
        add(0, 8'h04, 8'h00, 0, 3'd5, 0);
        add(0, 8'h04, 8'h04, 1, 3'd2, 0);
        add(0, 8'h00, 8'h00, 0, 3'd2, 0);
        add(0, 8'h00, 8'h00, 0, 3'd2, 0);

        // All requesting from reset: 7,6,...,0,7 each 4 cycles + timeout gap.
        add(1, 8'h00, 8'h00, 0, 3'd0, 0);
        for (int s = 0; s < 9; s++) begin
            int o;
            o = (15 - s) % 8;
            for (int c = 0; c < 4; c++)
                add(0, 8'hFF, 8'(1 << o), 1, 3'(o), 0);
            add(0, 8'hFF, 8'h00, 0, 3'(o), 1);
        end
        add(0, 8'h00, 8'h00, 0, 3'd7, 0);

        // Lone requester 3 times out and is re-granted after one gap cycle.
        for (int c = 0; c < 4; c++)
            add(0, 8'h08, 8'h08, 1, 3'd3, 0);
        add(0, 8'h08, 8'h00, 0, 3'd3, 1);
        add(0, 8'h08, 8'h08, 1, 3'd3, 0);
        add(0, 8'h00, 8'h00, 0, 3'd3, 0);

        // Owner 6 drops on its last allowed cycle: plain release, no timeout.
        add(1, 8'h00, 8'h00, 0, 3'd0, 0);
        for (int c = 0; c < 4; c++)
            add(0, 8'h4A, 8'h40, 1, 3'd6, 0);
        add(0, 8'h0A, 8'h00, 0, 3'd6, 0);
        add(0, 8'h0A, 8'h08, 1, 3'd3, 0);
        add(0, 8'h00, 8'h00, 0, 3'd3, 0);

        // Short req[1] pulse during owner 4 is ignored.
        add(1, 8'h00, 8'h00, 0, 3'd0, 0);
        add(0, 8'h10, 8'h10, 1, 3'd4, 0);
        add(0, 8'h12, 8'h10, 1, 3'd4, 0);
        add(0, 8'h10, 8'h10, 1, 3'd4, 0);
        add(0, 8'h00, 8'h00, 0, 3'd4, 0);
        add(0, 8'h00, 8'h00, 0, 3'd4, 0);

        // Owner 2 mid-grant, ahead of the asynchronous reset sequence.
        add(1, 8'h00, 8'h00, 0, 3'd0, 0);
        add(0, 8'h04, 8'h04, 1, 3'd2, 0);
        add(0, 8'h85, 8'h04, 1, 3'd2, 0);

        foreach (tbl[k]) begin
            resetn = !tbl[k].rst;
            req    = tbl[k].req;
            @(negedge clock);
            check($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].vld,
                  tbl[k].idx, tbl[k].to);
        end

        // Asynchronous reset mid-grant: outputs clear without a clock edge.
        #2;
        resetn = 1'b0;
        #1;
        check("async_rst", 8'h00, 1'b0, 3'd0, 1'b0);
        @(negedge clock);
        check("rst_hold", 8'h00, 1'b0, 3'd0, 1'b0);
        resetn = 1'b1;
        req    = 8'h85;
        @(negedge clock);
        check("post_rst_msb", 8'h80, 1'b1, 3'd7, 1'b0);
        req = 8'h00;
        @(negedge clock);
        check("post_rst_rel", 8'h00, 1'b0, 3'd7, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
